// File: rtl/loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot loader.
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StRecv  = ST_RECV,
    StWrite = ST_WRITE,
    StDone  = ST_DONE,
    StErr   = ST_ERR
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// MSB-first byte-to-word shift buffer with a wrapping byte-lane counter.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic              clear,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] buf_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      buf_q <= {buf_q[WORD_W-9:0], din};
      // Counter wraps to 0 on the last lane so the next word starts clean.
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign word = buf_q;
  // Asserted while waiting for the final byte of a word.
  assign full = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs a byte stream into words and holds
// the CPU until the whole program is in memory.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, word_cnt_q, len_clamped;
  logic [IDLE_W-1:0] idle_q;
  logic              accept, start_ok, pk_full;
  logic [WORD_W-1:0] pk_word;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign accept      = s_valid && s_ready;
  assign start_ok    = start && (state_q == StIdle || state_q == StDone || state_q == StErr);

  byte_packer u_packer (
    .clk   (clk),
    .clr   (clr),
    .push  (accept),
    .clear (start_ok),
    .din   (s_data),
    .word  (pk_word),
    .full  (pk_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) state_d = (len_clamped == '0) ? StDone : StRecv;
      end
      StRecv: begin
        if (accept && pk_full) begin
          state_d = StWrite;
        end else if (!accept && idle_q == IDLE_W'(TIMEOUT - 1)) begin
          state_d = StErr;
        end
      end
      StWrite: begin
        state_d = (word_cnt_q + LEN_W'(1) == len_q) ? StDone : StRecv;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      idle_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q      <= len_clamped;
        word_cnt_q <= '0;
        idle_q     <= '0;
      end else if (state_q == StRecv) begin
        idle_q <= accept ? '0 : idle_q + IDLE_W'(1);
      end else if (state_q == StWrite) begin
        word_cnt_q <= word_cnt_q + LEN_W'(1);
      end
    end
  end

  // Low bits of the word counter are the write address; the clamp keeps it below 2^ADDR_W.
  assign mem_addr  = word_cnt_q[ADDR_W-1:0];
  assign mem_wdata = pk_word;
  assign s_ready   = (state_q == StRecv);
  assign mem_we    = (state_q == StWrite);
  assign busy      = (state_q == StRecv) || (state_q == StWrite);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StErr);
  assign cpu_hold  = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; instance b uses a short timeout.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [8:0] len = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;

  logic        a_ready, a_we, a_hold, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_ready, b_we, b_hold, b_busy, b_done, b_err;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  wa_addr [0:511];
  logic [31:0] wa_data [0:511];
  int          wa_n = 0;
  int          wb_n = 0;

  imem_loader #(.ADDR_W(8), .TIMEOUT(1000)) dut_a (
    .clk(clk), .clr(clr), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(a_ready), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done), .err(a_err)
  );

  imem_loader #(.ADDR_W(8), .TIMEOUT(8)) dut_b (
    .clk(clk), .clr(clr), .start(start), .len(len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .err(b_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_we) begin
      if (wa_n < 512) begin
        wa_addr[wa_n] = a_addr;
        wa_data[wa_n] = a_wdata;
      end
      wa_n = wa_n + 1;
    end
    if (b_we) wb_n = wb_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests = tests + 1;
    assert (got === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and hold it until instance a accepts it, then idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!a_ready && k < 20) begin
      tick();
      k = k + 1;
    end
    if (!a_ready) chk("send_ready_timeout", {63'd0, a_ready}, 64'd1);
    tick();
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = 9'(n);
    tick();
    start = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 7 + 3) % 256);
  endfunction

  initial begin
    int base, base_b, bad;
    logic [31:0] exp_w;

    // Reset values
    #3;
    chk("rst_s_ready", {63'd0, a_ready}, 64'd0);
    chk("rst_mem_we", {63'd0, a_we}, 64'd0);
    chk("rst_mem_addr", {56'd0, a_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, a_wdata}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_done", {63'd0, a_done}, 64'd0);
    chk("rst_err", {63'd0, a_err}, 64'd0);
    chk("rst_cpu_hold", {63'd0, a_hold}, 64'd1);
    tick();
    clr = 1'b0;
    tick();

    // Continuous two-word load
    base = wa_n;
    do_start(2);
    chk("t1_busy_after_start", {63'd0, a_busy}, 64'd1);
    chk("t1_ready_after_start", {63'd0, a_ready}, 64'd1);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    chk("t1_we0", {63'd0, a_we}, 64'd1);
    chk("t1_addr0", {56'd0, a_addr}, 64'd0);
    chk("t1_wdata0", {32'd0, a_wdata}, 64'h12345678);
    chk("t1_ready_in_write", {63'd0, a_ready}, 64'd0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    s_valid = 1'b0;
    chk("t1_we1", {63'd0, a_we}, 64'd1);
    chk("t1_addr1", {56'd0, a_addr}, 64'd1);
    chk("t1_wdata1", {32'd0, a_wdata}, 64'hAABBCCDD);
    chk("t1_hold_during_last_write", {63'd0, a_hold}, 64'd1);
    tick();
    chk("t1_done", {63'd0, a_done}, 64'd1);
    chk("t1_cpu_hold", {63'd0, a_hold}, 64'd0);
    chk("t1_busy_end", {63'd0, a_busy}, 64'd0);
    repeat (3) tick();
    chk("t1_write_count", 64'(wa_n - base), 64'd2);

    // Same load with 3-cycle stalls between bytes
    base = wa_n;
    do_start(2);
    chk("t2_done_cleared", {63'd0, a_done}, 64'd0);
    send(8'h12, 3); send(8'h34, 3); send(8'h56, 3); send(8'h78, 3);
    send(8'hAA, 3); send(8'hBB, 3); send(8'hCC, 3); send(8'hDD, 3);
    chk("t2_done", {63'd0, a_done}, 64'd1);
    chk("t2_write_count", 64'(wa_n - base), 64'd2);
    chk("t2_addr0", {56'd0, wa_addr[base]}, 64'd0);
    chk("t2_data0", {32'd0, wa_data[base]}, 64'h12345678);
    chk("t2_addr1", {56'd0, wa_addr[base + 1]}, 64'd1);
    chk("t2_data1", {32'd0, wa_data[base + 1]}, 64'hAABBCCDD);

    // Timeout on instance b (TIMEOUT = 8) with a partial word
    clr = 1'b1; tick(); clr = 1'b0; tick();
    base_b = wb_n;
    do_start(1);
    send(8'h01, 0); send(8'h02, 0);
    s_valid = 1'b0;
    repeat (7) tick();
    chk("t3_err_before_timeout", {63'd0, b_err}, 64'd0);
    chk("t3_busy_before_timeout", {63'd0, b_busy}, 64'd1);
    tick();
    chk("t3_err", {63'd0, b_err}, 64'd1);
    chk("t3_cpu_hold", {63'd0, b_hold}, 64'd1);
    chk("t3_busy", {63'd0, b_busy}, 64'd0);
    chk("t3_no_write", 64'(wb_n - base_b), 64'd0);
    do_start(0);
    chk("t3_err_cleared", {63'd0, b_err}, 64'd0);
    chk("t3_len0_done", {63'd0, b_done}, 64'd1);
    chk("t3_a_ignores_start", {63'd0, a_busy}, 64'd1);

    // len = 0 and clamped len = 300 on instance a
    clr = 1'b1; tick(); clr = 1'b0; tick();
    base = wa_n;
    do_start(0);
    chk("t4_len0_done", {63'd0, a_done}, 64'd1);
    chk("t4_len0_busy", {63'd0, a_busy}, 64'd0);
    repeat (3) tick();
    chk("t4_len0_no_write", 64'(wa_n - base), 64'd0);
    base = wa_n;
    do_start(300);
    for (int i = 0; i < 1024; i++) send(pat(i), 0);
    s_valid = 1'b0;
    repeat (3) tick();
    chk("t4_clamp_count", 64'(wa_n - base), 64'd256);
    chk("t4_clamp_done", {63'd0, a_done}, 64'd1);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      exp_w = {pat(4 * k), pat(4 * k + 1), pat(4 * k + 2), pat(4 * k + 3)};
      if (wa_addr[base + k] !== 8'(k) || wa_data[base + k] !== exp_w) bad = bad + 1;
    end
    chk("t4_clamp_addr_data_errors", 64'(bad), 64'd0);

    // start pulsed mid-load is ignored
    base = wa_n;
    do_start(2);
    send(8'h01, 0); send(8'h02, 0);
    s_valid = 1'b0;
    do_start(1);
    send(8'h03, 0); send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
    send(8'h07, 0); send(8'h08, 0);
    s_valid = 1'b0;
    tick();
    chk("t5_midstart_count", 64'(wa_n - base), 64'd2);
    chk("t5_midstart_data0", {32'd0, wa_data[base]}, 64'h01020304);
    chk("t5_midstart_data1", {32'd0, wa_data[base + 1]}, 64'h05060708);
    chk("t5_midstart_done", {63'd0, a_done}, 64'd1);

    // clr between bytes 2 and 3 of word 5
    base = wa_n;
    do_start(8);
    for (int i = 0; i < 22; i++) send(pat(i + 40), 0);
    s_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("t5_clr_busy", {63'd0, a_busy}, 64'd0);
    chk("t5_clr_ready", {63'd0, a_ready}, 64'd0);
    chk("t5_clr_hold", {63'd0, a_hold}, 64'd1);
    chk("t5_clr_wdata", {32'd0, a_wdata}, 64'd0);
    chk("t5_clr_addr", {56'd0, a_addr}, 64'd0);
    tick(); tick();
    clr = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h5A;
    repeat (10) tick();
    s_valid = 1'b0;
    chk("t5_clr_write_count", 64'(wa_n - base), 64'd5);
    chk("t5_clr_idle_ready", {63'd0, a_ready}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, packs bytes MSB-first into 32-bit words, and writes them to consecutive word addresses of the instruction memory. It holds the CPU (PC and fetch) stalled until a complete program has been written. It is the write-side counterpart of the PC-driven fetch path and sits between the host/serial front end and the instruction memory write port.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; matches the PC width.
- `TIMEOUT`, 1000: idle cycles allowed between accepted bytes before a load aborts. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; `len` is sampled on the same edge.
- `len`  in  ADDR_W+1  number of words to load. 0 means no writes. Values above 2^ADDR_W are clamped to 2^ADDR_W.
- `s_valid`  in  1  byte available on `s_data`.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  stalls the PC and fetch while high.
- `busy`  out  1  load in progress.
- `done`  out  1  sticky: last load completed.
- `err`  out  1  sticky: last load aborted on timeout.

## Operation
- State machine states: IDLE, RECV, WRITE, DONE, ERR.
- IDLE (reset state):
  - On `start`, latch the clamped `len` and clear the byte and word counters, the idle counter, `done` and `err`.
  - If the latched length is 0, go to DONE; otherwise go to RECV.
- RECV:
  - `s_ready` = 1. A byte is accepted on any edge where `s_valid` && `s_ready`.
  - On accept, shift the byte into the low end of a 32-bit buffer. The first byte ends up in bits [31:24].
  - On accept, increment the byte counter (0..3) and clear the idle counter.
  - Accepting the 4th byte moves the FSM to WRITE.
  - On a cycle with no accept, increment the idle counter. When it reaches `TIMEOUT`, go to ERR.
- WRITE (exactly one cycle):
  - `mem_we` = 1, `mem_addr` = word counter, `mem_wdata` = buffer, `s_ready` = 0.
  - Then increment the word counter.
  - If the incremented count equals the latched length, go to DONE; otherwise go to RECV with the byte counter at 0.
- DONE: `done` = 1 and `cpu_hold` = 0. `start` begins a new load.
- ERR: `err` = 1 and `cpu_hold` = 1. `start` begins a new load.
- `start` is ignored in RECV and WRITE.
- `busy` = 1 in RECV and WRITE.
- `cpu_hold` = 0 only in DONE.
- Word addresses never wrap. Because of the clamp, the final address is at most 2^ADDR_W − 1.
- Partial word at timeout: the bytes already received are discarded and are not written.

## Timing
- Reset values: `s_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `err` 0, `cpu_hold` 1.
- `clr` takes effect immediately and asynchronously. Asserting it mid-load aborts the load with no further writes, and all outputs take their reset values.
- `s_ready`, `mem_we` and `busy` decode from the registered state and are glitch-free.
- `mem_addr` and `mem_wdata` are registered.
- 4th byte accepted at edge N → `mem_we` is high in cycle N+1 and `s_ready` is low in that cycle. `s_ready` is high again from cycle N+2 unless the load finished.
- Throughput with `s_valid` held high: 5 cycles per word.
- Last write at cycle N+1 → `done` = 1 and `cpu_hold` = 0 from edge N+2.
- `start` accepted at edge S → `busy` = 1 from S.
- `len` = 0 → `done` = 1 one cycle after S, with no `mem_we`.
- Timeout: after `TIMEOUT` consecutive idle cycles in RECV, the FSM is in ERR on the next edge.

## Structure
- Shared package `loader_pkg`: FSM state encoding (3-bit localparams) and the byte-lane constants `BYTES_PER_WORD` = 4 and `WORD_W` = 32.
- Sub-module `byte_packer`: the 32-bit shift buffer and 2-bit byte counter. It has `push`, `clear` and `full` pins. The FSM, word counter and timeout counter live in the top.

## Test plan
- Reset, then `start` with `len` = 2, stream 12 34 56 78 AA BB CC DD continuously → writes 0x12345678 @0 and 0xAABBCCDD @1, one `mem_we` each; `done` = 1 and `cpu_hold` = 0 two cycles after the last byte.
- Same load with `s_valid` deasserted for 3 cycles between each byte (`TIMEOUT` = 1000) → identical writes; the stall causes no extra or duplicate `mem_we`.
- `TIMEOUT` = 8, `len` = 1, send 2 bytes and then stop → ERR after 8 idle cycles: `err` = 1, `cpu_hold` = 1, no `mem_we`. A new `start` clears `err`.
- `len` = 0 → `done` one cycle after `start`, no writes. `len` = 300 → exactly 256 writes, addresses 0..255, no wrap.
- `start` pulsed mid-load → ignored, with no counter reset. `clr` asserted between bytes 2 and 3 of word 5 → outputs return to reset values immediately and no further writes occur.
